// File: rtl/ahb_dmem_if.sv
// AHB-Lite bus bundle between the core's data master and the data-memory slave.
interface ahb_dmem_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  // HREADY is the bus-level ready mux, so the master side (or the fabric) drives it.
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_dmem_slave.sv
// AHB-Lite data-memory responder: byte/half/word accesses into a little-endian
// RAM, programmable wait states, two-cycle ERROR for illegal transfers.
module ahb_dmem_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       rst,
  ahb_dmem_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Counter value loaded at acceptance so WAIT lasts exactly WAIT_STATES cycles.
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            wcnt_q, wcnt_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;

  logic                  can_accept;
  logic                  accept;
  logic                  size_err;
  logic                  align_err;
  logic                  range_err;
  logic                  xfer_err;
  logic                  ready;
  logic                  resp;
  logic [3:0]            be;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           rd_word;

  // Only cycles in which this slave drives HREADYOUT high can close an address phase.
  assign can_accept = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign accept     = can_accept && bus.HSEL && bus.HTRANS[1] && bus.HREADY;

  // Classify the transfer presented in the current address phase.
  always_comb begin
    size_err  = (bus.HSIZE > 3'd2);
    align_err = ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
    range_err = ((bus.HADDR >> (ADDR_WIDTH + 2)) != 32'd0);
    xfer_err  = size_err || align_err || range_err;
  end

  // Next-state, latched transfer and response outputs.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    ready   = 1'b1;
    resp    = 1'b0;

    case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        resp    = (state_q == S_ERR2);
        state_d = S_IDLE;
        if (accept) begin
          addr_d  = bus.HADDR[ADDR_WIDTH+1:0];
          size_d  = bus.HSIZE[1:0];
          // An errored transfer must never reach the RAM write port.
          write_d = bus.HWRITE && !xfer_err;
          if (xfer_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            wcnt_d  = WAIT_LOAD;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_WAIT: begin
        ready = 1'b0;
        if (wcnt_q == 3'd0) begin
          state_d = S_DATA;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      S_ERR1: begin
        ready   = 1'b0;
        resp    = 1'b1;
        state_d = S_ERR2;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state register; memory contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= 3'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // Little-endian lane enables from the latched size and low address bits.
  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'd0:    be[addr_q[1:0]] = 1'b1;
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign word_idx = addr_q[ADDR_WIDTH+1:2];
  // A reset landing on the closing edge drops the pending write.
  assign wr_en    = (state_q == S_DATA) && write_q && !rst;
  assign rd_en    = (state_q == S_DATA) && !write_q;

  // One byte-wide RAM per lane so partial writes need no read-modify-write.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      // Lane write on the edge that closes a write data phase.
      always_ff @(posedge clk) begin
        if (wr_en && be[gi]) begin
          lane_mem[word_idx] <= bus.HWDATA[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

  assign bus.HREADYOUT = ready;
  assign bus.HRESP     = resp;
  assign bus.HRDATA    = rd_en ? rd_word : 32'd0;

endmodule

// File: tb/tb_ahb_dmem_slave.sv
// Randomized AHB-Lite master with a transaction-level memory model for ahb_dmem_slave.
module tb_ahb_dmem_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;

  ahb_dmem_if if0 ();
  ahb_dmem_if if3 ();

  assign if0.HSEL   = hsel;   assign if3.HSEL   = hsel;
  assign if0.HADDR  = haddr;  assign if3.HADDR  = haddr;
  assign if0.HTRANS = htrans; assign if3.HTRANS = htrans;
  assign if0.HWRITE = hwrite; assign if3.HWRITE = hwrite;
  assign if0.HSIZE  = hsize;  assign if3.HSIZE  = hsize;
  assign if0.HWDATA = hwdata; assign if3.HWDATA = hwdata;
  assign if0.HREADY = if0.HREADYOUT;
  assign if3.HREADY = if3.HREADYOUT;

  ahb_dmem_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  ahb_dmem_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  bit          sel;
  logic        cur_rdy;
  logic        cur_resp;
  logic [31:0] cur_rdata;
  assign cur_rdy   = sel ? if3.HREADYOUT : if0.HREADYOUT;
  assign cur_resp  = sel ? if3.HRESP     : if0.HRESP;
  assign cur_rdata = sel ? if3.HRDATA    : if0.HRDATA;

  // One expected bus cycle of the selected slave.
  typedef struct {
    bit          rdy;
    bit          resp;
    logic [31:0] data;
    logic [31:0] mask;
    bit          wr;
    int          widx;
    logic [3:0]  be;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mbyte [1024][4];
  bit          mval  [1024][4];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          wst;
  logic [31:0] ap_wdata;

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
    return (sz > 3'd2) || (sz == 3'd1 && a % 2 != 0) || (sz == 3'd2 && a % 4 != 0) || (a >= 32'd4096);
  endfunction

  function automatic exp_t mk(input bit rdy, input bit resp);
    exp_t e;
    e.rdy = rdy; e.resp = resp; e.data = 32'd0; e.mask = 32'hFFFF_FFFF;
    e.wr = 1'b0; e.widx = 0; e.be = 4'd0;
    return e;
  endfunction

  // Expected response cycles for a transfer accepted now.
  task automatic push(input logic [31:0] a, input bit w, input logic [2:0] sz);
    exp_t e;
    int lo;
    int n;
    if (is_err(a, sz)) begin
      q.push_back(mk(1'b0, 1'b1));
      q.push_back(mk(1'b1, 1'b1));
    end else begin
      for (int i = 0; i < wst; i++) q.push_back(mk(1'b0, 1'b0));
      e = mk(1'b1, 1'b0);
      e.widx = int'(a / 4);
      lo = int'(a % 4);
      n = 1 << sz;
      for (int b = 0; b < 4; b++) e.be[b] = (b >= lo) && (b < lo + n);
      if (w) begin
        e.wr = 1'b1;
      end else begin
        for (int b = 0; b < 4; b++) begin
          e.data[8*b +: 8] = mval[e.widx][b] ? mbyte[e.widx][b] : 8'h00;
          e.mask[8*b +: 8] = mval[e.widx][b] ? 8'hFF : 8'h00;
        end
      end
      q.push_back(e);
    end
  endtask

  task automatic compare();
    exp_t e;
    e = (q.size() > 0) ? q[0] : mk(1'b1, 1'b0);
    n_cmp++;
    if (cur_rdy !== e.rdy || cur_resp !== e.resp || ((cur_rdata ^ e.data) & e.mask) !== 32'd0) begin
      n_bad++;
      $display("FAIL cycle t=%0t: got rdy=%0b resp=%0b rdata=%08h, need rdy=%0b resp=%0b rdata=%08h (mask %08h)",
               $time, cur_rdy, cur_resp, cur_rdata, e.rdy, e.resp, e.data, e.mask);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] need);
    n_cmp++;
    if (got !== need) begin
      n_bad++;
      $display("FAIL %s: got %08h need %08h", name, got, need);
    end
  endtask

  // Advance one clock: retire the current cycle in the model, accept, then compare.
  task automatic tick();
    exp_t e;
    bit   acc;
    acc = !rst && cur_rdy && hsel && htrans[1];
    if (rst) begin
      q.delete();
    end else if (q.size() > 0) begin
      e = q.pop_front();
      if (e.wr) begin
        for (int b = 0; b < 4; b++) begin
          if (e.be[b]) begin
            mbyte[e.widx][b] = hwdata[8*b +: 8];
            mval[e.widx][b]  = 1'b1;
          end
        end
      end
    end
    if (acc) push(haddr, hwrite, hsize);
    @(posedge clk);
    #1;
    if (acc) hwdata = hwrite ? ap_wdata : $urandom;
    else if (q.size() == 0) hwdata = $urandom;
    compare();
  endtask

  // Present one address phase; junk is driven while the slave stalls.
  task automatic issue(input bit s, input logic [1:0] t, input logic [31:0] a, input bit w,
                       input logic [2:0] sz, input logic [31:0] wd);
    int guard = 0;
    while (!cur_rdy && guard < 20) begin
      hsel = 1'($urandom); htrans = 2'($urandom); haddr = $urandom;
      hwrite = 1'($urandom); hsize = 3'($urandom);
      tick();
      guard++;
    end
    if (!cur_rdy) chk("stall_bound", {31'd0, cur_rdy}, 32'd1);
    hsel = s; htrans = t; haddr = a; hwrite = w; hsize = sz; ap_wdata = wd;
    tick();
    htrans = 2'b00;
  endtask

  task automatic write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    issue(1'b1, 2'b10, a, 1'b1, sz, wd);
  endtask

  task automatic read_word(input logic [31:0] a, output logic [31:0] d, output int stalls);
    issue(1'b1, 2'b10, a, 1'b0, 3'd2, 32'd0);
    stalls = 0;
    while (!cur_rdy && stalls < 20) begin
      stalls++;
      tick();
    end
    d = cur_rdata;
  endtask

  task automatic drain();
    int guard = 0;
    htrans = 2'b00;
    while (q.size() > 0 && guard < 20) begin
      tick();
      guard++;
    end
  endtask

  task automatic err_xfer(input string name, input logic [31:0] a, input logic [2:0] sz);
    logic r1, p1;
    issue(1'b1, 2'b10, a, 1'b1, sz, 32'h5A5A_5A5A);
    r1 = cur_rdy; p1 = cur_resp;
    tick();
    chk(name, {28'd0, r1, p1, cur_rdy, cur_resp}, 32'h7);
  endtask

  task automatic do_reset();
    rst = 1'b1; hsel = 1'b0; htrans = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_outputs", {cur_rdy, cur_resp, 30'd0} | (cur_rdata != 0 ? 32'h1 : 32'h0), 32'h8000_0000);
  endtask

  task automatic start_phase(input bit s, input int w);
    sel = s;
    wst = w;
    for (int i = 0; i < 1024; i++) for (int b = 0; b < 4; b++) mval[i][b] = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) write(32'(i * 4), 3'd2, $urandom);
  endtask

  task automatic random_run(input int n);
    logic [31:0] a;
    logic [2:0]  sz;
    int          r;
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else if (r < 9) begin
        case ($urandom_range(0, 2))
          0:       issue(1'b1, 2'b00, $urandom, 1'($urandom), 3'd2, $urandom);
          1:       issue(1'b1, 2'b01, $urandom, 1'($urandom), 3'd2, $urandom);
          default: issue(1'b0, 2'b10, $urandom_range(0, 63), 1'b1, 3'd2, $urandom);
        endcase
      end else begin
        sz = ($urandom_range(0, 99) < 90) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
        a  = 32'($urandom_range(0, 15) * 4);
        if ($urandom_range(0, 99) < 15)      a = a + 32'($urandom_range(0, 3));
        else if (sz == 3'd0)                 a = a + 32'($urandom_range(0, 3));
        else if (sz == 3'd1)                 a = a + 32'($urandom_range(0, 1) * 2);
        if ($urandom_range(0, 99) < 7)       a = $urandom | 32'h0000_1000;
        issue(1'b1, 2'($urandom_range(2, 3)), a, 1'($urandom), sz, $urandom);
        if ($urandom_range(0, 99) < 30) tick();
      end
    end
    drain();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, need finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          s;
    rst = 1'b1; hsel = 1'b0; haddr = 32'd0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd0; hwdata = 32'd0; ap_wdata = 32'd0;

    // Zero wait states.
    start_phase(1'b0, 0);
    write(32'h10, 3'd2, 32'hDEAD_BEEF);
    read_word(32'h10, d, s);
    chk("w0_read_data", d, 32'hDEAD_BEEF);
    chk("w0_read_stalls", 32'(s), 32'd0);
    write(32'h20, 3'd2, 32'h1122_3344);
    write(32'h23, 3'd0, 32'hAA00_0000);
    write(32'h20, 3'd1, 32'h0000_BEEF);
    read_word(32'h20, d, s);
    chk("merge_data", d, 32'hAA22_BEEF);
    write(32'h0, 3'd2, 32'h0BAD_F00D);
    drain();
    err_xfer("err_word_misalign", 32'h22, 3'd2);
    err_xfer("err_half_misalign", 32'h21, 3'd1);
    err_xfer("err_size3", 32'h20, 3'd3);
    err_xfer("err_range", 32'h1000, 3'd2);
    read_word(32'h20, d, s);
    chk("err_mem_unchanged", d, 32'hAA22_BEEF);
    read_word(32'h0, d, s);
    chk("err_range_no_alias", d, 32'h0BAD_F00D);
    issue(1'b1, 2'b00, 32'h20, 1'b1, 3'd2, 32'h0);
    issue(1'b1, 2'b01, 32'h20, 1'b1, 3'd2, 32'h0);
    issue(1'b0, 2'b10, 32'h20, 1'b1, 3'd2, 32'h0);
    chk("idle_rdata", cur_rdata, 32'd0);
    read_word(32'h20, d, s);
    chk("idle_mem_unchanged", d, 32'hAA22_BEEF);
    random_run(400);

    // Three wait states.
    start_phase(1'b1, 3);
    write(32'h20, 3'd2, 32'h1122_3344);
    read_word(32'h20, d, s);
    chk("w3_read_stalls", 32'(s), 32'd3);
    chk("w3_read_data", d, 32'h1122_3344);
    err_xfer("w3_err_latency", 32'h22, 3'd2);
    write(32'h30, 3'd2, 32'hCAFE_F00D);
    drain();
    write(32'h30, 3'd2, 32'h1234_5678);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_ready_resp", {30'd0, cur_rdy, cur_resp}, 32'h2);
    read_word(32'h30, d, s);
    chk("rst_mid_write_dropped", d, 32'hCAFE_F00D);
    random_run(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
